wb_master_ctrl: RTL and testbench
=================================

// Module: wb_master_ctrl
// PURPOSE
//  Single-outstanding Wishbone classic master. Accepts a command (addr/wdata/we) on a
//  valid/ready port, runs one cyc/stb bus cycle to a slave, waits for ack or timeout,
//  and returns read data and error status on a valid/ready response port. Sits
//  directly upstream of Wishbone slaves (register blocks) and is driven by the core/test host.
// PARAMETERS
//  ADDR_WIDTH   32  width of cmd_addr / addr_out
//  DATA_WIDTH   32  width of data paths
//  TIMEOUT      64  max cycles in BUS state awaiting ack; 0 = no timeout (wait forever)
//  GAP_CYCLES   8   min cycles cyc_out held low between consecutive bus cycles (>=1)
// PORTS
//  clock        in   1           clock
//  reset        in   1           reset, synchronous, active-high
//  cmd_valid    in   1           command offered
//  cmd_ready    out  1           command accepted when valid&&ready at posedge
//  cmd_addr     in   ADDR_WIDTH  target address
//  cmd_wdata    in   DATA_WIDTH  write data (ignored for reads)
//  cmd_we       in   1           1 = write, 0 = read
//  rsp_valid    out  1           response available
//  rsp_ready    in   1           response consumed when valid&&ready at posedge
//  rsp_rdata    out  DATA_WIDTH  read data (0 for writes and errors)
//  rsp_err      out  1           1 = bus cycle timed out
//  addr_out     out  ADDR_WIDTH  Wishbone address
//  data_out     out  DATA_WIDTH  Wishbone write data
//  data_in      in   DATA_WIDTH  Wishbone read data
//  we_out       out  1           Wishbone write enable
//  cyc_out      out  1           Wishbone cycle
//  strobe_out   out  1           Wishbone strobe (always equal to cyc_out)
//  ack_in       in   1           Wishbone ack
// BEHAVIOUR
//  - Reset: state IDLE; cyc_out/strobe_out/we_out=0; addr_out/data_out=0; rsp_valid=0,
//    rsp_rdata=0, rsp_err=0; timeout and gap counters=0. Reset mid-cycle drops cyc
//    at the reset edge; any pending command/response is discarded.
//  - All outputs registered except cmd_ready = (state==IDLE) && (gap_cnt==0).
//  - States: IDLE -> BUS on cmd accept; BUS -> RESP on ack or timeout; RESP -> IDLE on
//    rsp_valid&&rsp_ready. No other transitions.
//  - IDLE: on accept latch addr/wdata/we into addr_out/data_out/we_out; cyc_out and
//    strobe_out go high the next cycle (1-cycle accept-to-bus latency). timeout cnt=0.
//  - BUS: bus outputs held stable. ack_in sampled at posedge only in BUS; ack_in in
//    IDLE/RESP is ignored. On ack: rsp_rdata <= we_out ? 0 : data_in, rsp_err <= 0,
//    rsp_valid <= 1, cyc/stb <= 0, gap_cnt <= GAP_CYCLES-1.
//  - Timeout (TIMEOUT>0): counter increments each BUS cycle without ack; at the edge
//    where count==TIMEOUT-1 and no ack: rsp_err<=1, rsp_rdata<=0, same exit as ack.
//    Ack and timeout in the same cycle: ack wins (rsp_err=0).
//  - Bus cycle with slave ack latency L (cycles from cyc high to ack high) completes in
//    L+1 cycles in BUS; L>=TIMEOUT gives err.
//  - RESP: rsp_valid/rsp_rdata/rsp_err held stable until rsp_ready; rsp_valid drops on
//    the accepting edge. Same-cycle rsp accept and new cmd not possible (cmd_ready=0).
//  - gap_cnt decrements to 0 from the cycle after cyc drops, independent of state;
//    guarantees >=GAP_CYCLES cycles of cyc_out low before next cyc_out high.
//  - we_out/addr_out/data_out keep last values after cycle ends (don't-care while cyc=0).
//  - Counter widths: $clog2(TIMEOUT+1), $clog2(GAP_CYCLES+1); no wrap (saturating compare).
// STRUCTURE
//  - Shared package/include wb_defs: state encodings (IDLE=2'd0, BUS=2'd1, RESP=2'd2),
//    default WB address/data widths. No sub-module; counters and FSM inline.
// TESTING
//  - Read: cmd addr=0x1, we=0; slave acks 8 cycles after cyc with data 0xDEADBEEF ->
//    rsp_valid, rsp_rdata=0xDEADBEEF, rsp_err=0; cyc high exactly 9 cycles.
//  - Write: cmd addr=0x0, wdata=0x12345678, we=1 -> data_out/we_out stable while cyc
//    high; rsp_rdata=0, rsp_err=0; read-back of addr 0 returns 0x12345678.
//  - Timeout: TIMEOUT=16, slave never acks -> cyc drops after 16 BUS cycles,
//    rsp_err=1, rsp_rdata=0; ack at count 15 instead -> rsp_err=0.
//  - Backpressure/gap: rsp_ready low 5 cycles -> response held stable; back-to-back
//    cmds -> cmd_ready low and cyc low >=8 cycles between bus cycles; stray ack in IDLE ignored.
//  - Reset mid-BUS: assert reset 3 cycles into a read -> cyc_out=0, rsp_valid=0 next
//    cycle; cmd_ready=1 first cycle after reset release; next read completes normally.

Source files
------------

// File: rtl/wb_defs.sv
// Shared Wishbone master definitions: FSM state encoding, default bus widths
// and a counter-width helper used to size the timeout and gap counters.
package wb_defs;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    // Bits needed to hold values 0..n; a disabled (zero) limit still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone classic master: one command in, one cyc/stb bus
// cycle out, one response back, with an ack timeout and an enforced idle gap
// between consecutive bus cycles.
module wb_master_ctrl
    import wb_defs::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_we,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  we_out,
    output logic                  cyc_out,
    output logic                  strobe_out,
    input  logic                  ack_in
);

    localparam int TO_W  = cnt_width(TIMEOUT);
    localparam int GAP_W = cnt_width(GAP_CYCLES);

    // Last count value before a timeout fires; unused when TIMEOUT is zero.
    localparam logic [TO_W-1:0]  TO_LAST    = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

    wb_state_t        state;
    wb_state_t        next_state;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic accept;
    logic ack_hit;
    logic to_hit;
    logic bus_done;
    logic rsp_take;

    // Only the command handshake is combinational; everything else is registered.
    assign cmd_ready  = (state == IDLE) && (gap_cnt == '0);
    assign accept     = cmd_valid && cmd_ready;
    // ack_in only matters while a bus cycle is in flight.
    assign ack_hit    = (state == BUS) && ack_in;
    // Ack wins over a timeout landing on the same edge.
    assign to_hit     = (state == BUS) && !ack_in && (TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign bus_done   = ack_hit || to_hit;
    assign rsp_take   = (state == RESP) && rsp_ready;
    assign strobe_out = cyc_out;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: IDLE -> BUS -> RESP -> IDLE, nothing else.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = BUS;
            BUS:     if (bus_done) next_state = RESP;
            RESP:    if (rsp_take) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Wishbone request side: latch the command on accept, hold it through BUS.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_out <= '0;
            data_out <= '0;
            we_out   <= 1'b0;
            cyc_out  <= 1'b0;
        end else if (accept) begin
            addr_out <= cmd_addr;
            data_out <= cmd_wdata;
            we_out   <= cmd_we;
            cyc_out  <= 1'b1;
        end else if (bus_done) begin
            cyc_out  <= 1'b0;
        end
    end

    // Response side: capture result at bus completion, hold until consumed.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (ack_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= we_out ? '0 : data_in;
            rsp_err   <= 1'b0;
        end else if (to_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
        end
    end

    // Timeout counter: cleared on accept, counts BUS cycles without ack, saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if ((state == BUS) && !ack_in && (to_cnt != TO_LAST)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Gap counter: reloaded as cyc drops, then runs down to zero regardless of state.
    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (bus_done) begin
            gap_cnt <= GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: latency-programmable Wishbone slave, bus-shape
// monitor and a response scoreboard filled as commands are accepted.
module tb_wb_master_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int GAP = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_we;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic [DW-1:0] data_in;
    logic          we_out;
    logic          cyc_out;
    logic          strobe_out;
    logic          ack_in;

    wb_master_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .GAP_CYCLES(GAP)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_we(cmd_we),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .addr_out(addr_out), .data_out(data_out), .data_in(data_in),
        .we_out(we_out), .cyc_out(cyc_out), .strobe_out(strobe_out), .ack_in(ack_in)
    );

    initial forever #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] ref_mem [0:15];
    logic [DW-1:0] slv_mem [0:15];
    int slv_lat   = 0;
    bit slv_never = 1'b0;
    bit force_ack = 1'b0;

    assign data_in = slv_mem[addr_out[3:0]];

    // Slave: acks slv_lat cycles after cyc rises (cycle 0 = first cyc-high cycle).
    initial begin
        int lat_cnt;
        for (int i = 0; i < 16; i++) slv_mem[i] = 32'hA500_0000 | 32'(i);
        slv_mem[1] = 32'hDEAD_BEEF;
        ack_in  = 1'b0;
        lat_cnt = 0;
        forever begin
            @(negedge clock);
            if (cyc_out && !reset) begin
                if (!slv_never && lat_cnt == slv_lat) begin
                    ack_in = 1'b1;
                    if (we_out) slv_mem[addr_out[3:0]] = data_out;
                end else begin
                    ack_in = 1'b0;
                end
                lat_cnt++;
            end else begin
                ack_in  = force_ack;
                lat_cnt = 0;
            end
        end
    end

    // Bus monitor: cyc-high lengths, shortest low gap, stability and stb==cyc.
    int cur_hi = 0, last_hi = 0, cur_lo = 0, min_gap = 1000, viol = 0;
    initial begin
        bit seen_hi, pc;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic pw;
        seen_hi = 1'b0; pc = 1'b0; pa = '0; pd = '0; pw = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                cur_hi = 0; cur_lo = 0; seen_hi = 1'b0; pc = 1'b0;
            end else begin
                if (strobe_out !== cyc_out) viol++;
                if (cyc_out) begin
                    if (pc && (addr_out !== pa || data_out !== pd || we_out !== pw)) viol++;
                    if (cur_hi == 0 && seen_hi && cur_lo < min_gap) min_gap = cur_lo;
                    cur_hi++;
                    cur_lo = 0;
                end else begin
                    if (cur_hi > 0) begin
                        last_hi = cur_hi;
                        seen_hi = 1'b1;
                    end
                    cur_hi = 0;
                    cur_lo++;
                end
                pa = addr_out; pd = data_out; pw = we_out; pc = cyc_out;
            end
        end
    end

    task automatic do_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                          input int lat, input bit never, input int hold);
        int n;
        exp_t e;
        logic [DW-1:0] r0;
        logic e0;
        bit ok;
        slv_lat = lat;
        slv_never = never;
        n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clock); #1; n++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_we = w;
        @(posedge clock);
        e.err   = never || (lat >= TO);
        e.rdata = (w || e.err) ? '0 : ref_mem[a[3:0]];
        if (w && !e.err) ref_mem[a[3:0]] = d;
        sb.push_back(e);
        #1 cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 0);
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clock); #1; n++; end
        chk("rsp_valid_wait", rsp_valid, 1);
        r0 = rsp_rdata; e0 = rsp_err; ok = 1'b1;
        repeat (hold) begin
            @(posedge clock); #1;
            if (!rsp_valid || rsp_rdata !== r0 || rsp_err !== e0) ok = 1'b0;
        end
        if (hold > 0) chk("rsp_hold", ok, 1);
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
        end
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
        chk("gap_block", cmd_ready, 0);
        chk("cyc_len", last_hi, e.err ? TO : lat + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        ref_mem[1] = 32'hDEAD_BEEF;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_we = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_cyc", cyc_out, 0);
        chk("rst_stb", strobe_out, 0);
        chk("rst_we", we_out, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        reset = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);

        do_cmd(32'h1, 32'h0, 1'b0, 8, 1'b0, 0);             // read DEADBEEF, 9 cycles
        do_cmd(32'h0, 32'h1234_5678, 1'b1, 3, 1'b0, 0);     // write
        do_cmd(32'h0, 32'h0, 1'b0, 2, 1'b0, 0);             // read-back, back-to-back
        do_cmd(32'h1, 32'h0, 1'b0, 0, 1'b1, 0);             // never acks -> err
        do_cmd(32'h1, 32'h0, 1'b0, 15, 1'b0, 0);            // ack at count 15 -> ok
        do_cmd(32'h1, 32'h0, 1'b0, 16, 1'b0, 0);            // one cycle too late -> err
        do_cmd(32'h5, 32'h0, 1'b0, 0, 1'b0, 5);             // backpressure 5 cycles
        do_cmd(32'h2, 32'hFFFF_0000, 1'b1, 0, 1'b1, 2);     // write times out
        do_cmd(32'h2, 32'h0, 1'b0, 1, 1'b0, 0);             // original value remains

        // Stray ack while idle must not start or finish anything.
        repeat (10) @(posedge clock);
        #1 force_ack = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
            if (rsp_valid || cyc_out || !cmd_ready) ok = 1'b0;
        end
        force_ack = 1'b0;
        chk("stray_ack", ok, 1);
        do_cmd(32'h3, 32'h0, 1'b0, 4, 1'b0, 0);

        // Reset three cycles into a read.
        slv_lat = 8; slv_never = 1'b0;
        n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clock); #1; n++; end
        chk("mid_rst_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = 32'h1; cmd_we = 1'b0;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_cyc", cyc_out, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        reset = 1'b0;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        do_cmd(32'h1, 32'h0, 1'b0, 8, 1'b0, 0);

        repeat (3) @(posedge clock);
        chk("min_gap_ok", (min_gap >= GAP) ? 1 : 0, 1);
        chk("bus_stable", viol, 0);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
